// File: rtl/mac_pkg.sv
// Shared types for the MAC frame engine.
// Holds the opcode and FSM state enums and the accumulator width helper.
package mac_pkg;

    typedef enum logic [2:0] {
        OP_ID   = 3'd0,
        OP_NOT  = 3'd1,
        OP_NEG  = 3'd2,
        OP_SHR  = 3'd3,
        OP_SHL  = 3'd4,
        OP_REP  = 3'd5,
        OP_RSV6 = 3'd6,
        OP_RSV7 = 3'd7
    } op_e;

    typedef enum logic {
        ST_ACC  = 1'b0,
        ST_HOLD = 1'b1
    } state_e;

    // Full product plus growth for num_terms additions plus one guard bit.
    function automatic int acc_width(int data_w, int num_terms);
        return 2 * data_w + $clog2(num_terms) + 1;
    endfunction

endpackage

// File: rtl/mac_pretransform.sv
// Combinational per-operand pre-transform selected by a 3-bit opcode.
// Ports: a (operand in), op (opcode), y (transformed operand, DATA_W bits).
module mac_pretransform
    import mac_pkg::*;
#(
    parameter int DATA_W = 6,
    parameter int SHAMT  = 4
) (
    input  logic [DATA_W-1:0] a,
    input  op_e               op,
    output logic [DATA_W-1:0] y
);

    always_comb begin
        y = '0;
        unique case (op)
            OP_ID:   y = a;
            OP_NOT:  y = ~a;
            // Wraps: the most negative value negates to itself.
            OP_NEG:  y = -a;
            OP_SHR:  y = $signed(a) >>> SHAMT;
            OP_SHL:  y = a << SHAMT;
            OP_REP:  y = {DATA_W{a[0]}};
            OP_RSV6: y = '0;
            OP_RSV7: y = '0;
        endcase
    end

endmodule

// File: rtl/mac_frame_engine.sv
// Streaming sum-of-products engine: transform, multiply, accumulate frames.
// Ports: clk/rst_n, clear, in_* valid/ready pair input, out_* valid/ready sum.
module mac_frame_engine
    import mac_pkg::*;
#(
    parameter int DATA_W    = 6,
    parameter int OUT_W     = 9,
    parameter int NUM_TERMS = 8,
    parameter int SHAMT     = 4
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              clear,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [DATA_W-1:0] in_a,
    input  logic [DATA_W-1:0] in_b,
    input  logic [2:0]        in_op,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [OUT_W-1:0]  out_q
);

    localparam int ACC_W  = acc_width(DATA_W, NUM_TERMS);
    localparam int PROD_W = 2 * DATA_W;
    localparam int CNT_W  = (NUM_TERMS > 1) ? $clog2(NUM_TERMS) : 1;

    state_e             state_q, state_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic               s1_valid_q, s1_valid_d;
    logic               s1_last_q, s1_last_d;
    logic [PROD_W-1:0]  s1_prod_q, s1_prod_d;
    logic [ACC_W-1:0]   acc_q, acc_d;
    logic               out_valid_q, out_valid_d;
    logic [OUT_W-1:0]   out_q_q, out_q_d;

    logic [DATA_W-1:0]  ta, tb;
    logic [PROD_W-1:0]  prod;
    logic [ACC_W-1:0]   prod_ext;
    logic [ACC_W-1:0]   acc_sum;
    logic               accept;
    logic               last_term;

    mac_pretransform #(.DATA_W(DATA_W), .SHAMT(SHAMT)) u_xf_a (
        .a  (in_a),
        .op (op_e'(in_op)),
        .y  (ta)
    );

    mac_pretransform #(.DATA_W(DATA_W), .SHAMT(SHAMT)) u_xf_b (
        .a  (in_b),
        .op (op_e'(in_op)),
        .y  (tb)
    );

    assign in_ready  = (state_q == ST_ACC);
    assign accept    = in_valid && in_ready;
    assign last_term = (cnt_q == CNT_W'(NUM_TERMS - 1));

    // Sign-extend both factors to the product width so the low PROD_W
    // bits of an unsigned multiply are the exact signed product.
    assign prod = {{DATA_W{ta[DATA_W-1]}}, ta} * {{DATA_W{tb[DATA_W-1]}}, tb};

    assign prod_ext = {{(ACC_W - PROD_W){s1_prod_q[PROD_W-1]}}, s1_prod_q};
    assign acc_sum  = acc_q + prod_ext;

    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q;
        s1_valid_d  = 1'b0;
        s1_last_d   = s1_last_q;
        s1_prod_d   = s1_prod_q;
        acc_d       = acc_q;
        out_valid_d = out_valid_q;
        out_q_d     = out_q_q;

        if (accept) begin
            s1_valid_d = 1'b1;
            s1_last_d  = last_term;
            s1_prod_d  = prod;
            cnt_d      = last_term ? '0 : cnt_q + CNT_W'(1);
        end

        if (out_valid_q && out_ready) begin
            out_valid_d = 1'b0;
        end

        if (s1_valid_q) begin
            if (s1_last_q) begin
                out_q_d     = acc_sum[OUT_W-1:0];
                out_valid_d = 1'b1;
                acc_d       = '0;
            end else begin
                acc_d = acc_sum;
            end
        end

        unique case (state_q)
            ST_ACC: begin
                if (accept && last_term) begin
                    state_d = ST_HOLD;
                end
            end
            ST_HOLD: begin
                if (out_valid_q && out_ready) begin
                    state_d = ST_ACC;
                end
            end
        endcase

        if (clear) begin
            state_d     = ST_ACC;
            cnt_d       = '0;
            acc_d       = '0;
            s1_valid_d  = 1'b0;
            out_valid_d = 1'b0;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= ST_ACC;
            cnt_q       <= '0;
            s1_valid_q  <= 1'b0;
            s1_last_q   <= 1'b0;
            s1_prod_q   <= '0;
            acc_q       <= '0;
            out_valid_q <= 1'b0;
            out_q_q     <= '0;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            s1_valid_q  <= s1_valid_d;
            s1_last_q   <= s1_last_d;
            s1_prod_q   <= s1_prod_d;
            acc_q       <= acc_d;
            out_valid_q <= out_valid_d;
            out_q_q     <= out_q_d;
        end
    end

    assign out_valid = out_valid_q;
    assign out_q     = out_q_q;

endmodule
